// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and 4-state FSM.
// Optional macro BUTTON_DEBOUNCER_EVENTS_EN adds one-cycle pressed/released pulses.
`timescale 1ns/100ps
module button_debouncer #(
    parameter int STABLE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic button_n_db,
    output logic busy
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
    ,
    output logic pressed_pulse,
    output logic released_pulse
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);
    localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 1);

    localparam logic [1:0] ST_RELEASED        = 2'd0;
    localparam logic [1:0] ST_PRESS_PENDING   = 2'd1;
    localparam logic [1:0] ST_PRESSED         = 2'd2;
    localparam logic [1:0] ST_RELEASE_PENDING = 2'd3;

    logic             sync1_r;
    logic             sync2_r;
    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] count_inc_s;
    logic             db_r;
    logic             db_s;
    logic             busy_r;
    logic             pending_s;

    // Next-state, counter and committed-level decode; only the synchronised level is examined.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        db_s        = db_r;
        count_inc_s = count_r + CNT_ONE;
        case (state_r)
            ST_RELEASED: begin
                if (!sync2_r) begin
                    if (SINGLE_CYCLE) begin
                        state_s = ST_PRESSED;
                        db_s    = 1'b0;
                        count_s = CNT_ZERO;
                    end else begin
                        state_s = ST_PRESS_PENDING;
                        count_s = CNT_ONE;
                    end
                end else begin
                    count_s = CNT_ZERO;
                end
            end
            ST_PRESS_PENDING: begin
                if (sync2_r) begin
                    state_s = ST_RELEASED;
                    count_s = CNT_ZERO;
                end else if (count_inc_s == CNT_LAST) begin
                    state_s = ST_PRESSED;
                    db_s    = 1'b0;
                    count_s = CNT_ZERO;
                end else begin
                    count_s = count_inc_s;
                end
            end
            ST_PRESSED: begin
                if (sync2_r) begin
                    if (SINGLE_CYCLE) begin
                        state_s = ST_RELEASED;
                        db_s    = 1'b1;
                        count_s = CNT_ZERO;
                    end else begin
                        state_s = ST_RELEASE_PENDING;
                        count_s = CNT_ONE;
                    end
                end else begin
                    count_s = CNT_ZERO;
                end
            end
            ST_RELEASE_PENDING: begin
                if (!sync2_r) begin
                    state_s = ST_PRESSED;
                    count_s = CNT_ZERO;
                end else if (count_inc_s == CNT_LAST) begin
                    state_s = ST_RELEASED;
                    db_s    = 1'b1;
                    count_s = CNT_ZERO;
                end else begin
                    count_s = count_inc_s;
                end
            end
            default: begin
                state_s = ST_RELEASED;
                db_s    = 1'b1;
                count_s = CNT_ZERO;
            end
        endcase
        pending_s = (state_s == ST_PRESS_PENDING) || (state_s == ST_RELEASE_PENDING);
    end

    // Synchroniser, FSM state, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            state_r <= ST_RELEASED;
            count_r <= CNT_ZERO;
            db_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            sync1_r <= button_n;
            sync2_r <= sync1_r;
            state_r <= state_s;
            count_r <= count_s;
            db_r    <= db_s;
            busy_r  <= pending_s;
        end
    end

    assign button_n_db = db_r;
    assign busy        = busy_r;

`ifdef BUTTON_DEBOUNCER_EVENTS_EN
    logic pressed_pulse_r;
    logic released_pulse_r;

    // Event pulses registered on the same edge the committed level changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressed_pulse_r  <= 1'b0;
            released_pulse_r <= 1'b0;
        end else begin
            pressed_pulse_r  <= db_r & ~db_s;
            released_pulse_r <= ~db_r & db_s;
        end
    end

    assign pressed_pulse  = pressed_pulse_r;
    assign released_pulse = released_pulse_r;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (STABLE_CYCLES=4 and STABLE_CYCLES=1 instances).
`timescale 1ns/100ps
module tb_button_debouncer;

    logic clock;
    logic reset;
    logic button_n;
    logic button_n_db;
    logic busy;
    logic pressed_pulse;
    logic released_pulse;
    logic reset1;
    logic button1_n;
    logic button1_n_db;
    logic busy1;
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
    logic pressed1_pulse;
    logic released1_pulse;
`endif

    int errors = 0;
    int checks = 0;

    button_debouncer #(.STABLE_CYCLES(4)) dut (
        .clock(clock),
        .reset(reset),
        .button_n(button_n),
        .button_n_db(button_n_db),
        .busy(busy)
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
        ,
        .pressed_pulse(pressed_pulse),
        .released_pulse(released_pulse)
`endif
    );

    button_debouncer #(.STABLE_CYCLES(1)) dut1 (
        .clock(clock),
        .reset(reset1),
        .button_n(button1_n),
        .button_n_db(button1_n_db),
        .busy(busy1)
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
        ,
        .pressed_pulse(pressed1_pulse),
        .released_pulse(released1_pulse)
`endif
    );

`ifndef BUTTON_DEBOUNCER_EVENTS_EN
    assign pressed_pulse  = 1'b0;
    assign released_pulse = 1'b0;
`endif

    initial clock = 1'b0;
    always #0.5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #0.1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset1 = 1'b1; button_n = 1'b1; button1_n = 1'b1;
        repeat (3) tick();
        reset = 1'b0; reset1 = 1'b0;
        tick();
        checks++;
        if (button_n_db !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: db=%b busy=%b expected db=1 busy=0", button_n_db, busy);
        end
        checks++;
        if (pressed_pulse !== 1'b0 || released_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: pp=%b rp=%b expected 0 0", pressed_pulse, released_pulse);
        end
        button_n = 1'b0;
        repeat (6) tick();
        checks++;
        if (button_n_db !== 1'b0) begin
            errors++;
            $display("FAIL reset_pre_press: db=%b expected 0", button_n_db);
        end
        #0.2 reset = 1'b1;
        #0.1;
        checks++;
        if (button_n_db !== 1'b1 || busy !== 1'b0 || pressed_pulse !== 1'b0 || released_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: db=%b busy=%b pp=%b rp=%b expected 1 0 0 0",
                     button_n_db, busy, pressed_pulse, released_pulse);
        end
        button_n = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_press();
        for (int e = 1; e <= 7; e++) begin
            button_n = 1'b0;
            tick();
            checks++;
            if (busy !== ((e >= 3 && e <= 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL press_busy e%0d: busy=%b", e, busy);
            end
            checks++;
            if (button_n_db !== ((e >= 6) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL press_db e%0d: db=%b", e, button_n_db);
            end
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
            checks++;
            if (pressed_pulse !== ((e == 6) ? 1'b1 : 1'b0) || released_pulse !== 1'b0) begin
                errors++;
                $display("FAIL press_pulse e%0d: pp=%b rp=%b", e, pressed_pulse, released_pulse);
            end
`endif
        end
    endtask

    task automatic test_release();
        // Two-edge glitch high while pressed must be rejected.
        for (int e = 1; e <= 10; e++) begin
            button_n = (e <= 2) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if (button_n_db !== 1'b0 || busy !== ((e == 3 || e == 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL glitch e%0d: db=%b busy=%b", e, button_n_db, busy);
            end
            checks++;
            if (released_pulse !== 1'b0) begin
                errors++;
                $display("FAIL glitch_pulse e%0d: rp=%b expected 0", e, released_pulse);
            end
        end
        for (int e = 1; e <= 7; e++) begin
            button_n = 1'b1;
            tick();
            checks++;
            if (busy !== ((e >= 3 && e <= 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL release_busy e%0d: busy=%b", e, busy);
            end
            checks++;
            if (button_n_db !== ((e >= 6) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL release_db e%0d: db=%b", e, button_n_db);
            end
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
            checks++;
            if (released_pulse !== ((e == 6) ? 1'b1 : 1'b0) || pressed_pulse !== 1'b0) begin
                errors++;
                $display("FAIL release_pulse e%0d: rp=%b pp=%b", e, released_pulse, pressed_pulse);
            end
`endif
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int e = 1; e <= 12; e++) begin
            button_n = (e == 4) ? 1'b1 : 1'b0;
            tick();
            if (pressed_pulse === 1'b1) pulses++;
            checks++;
            if (busy !== ((e == 3 || e == 4 || e == 5 || e == 7 || e == 8 || e == 9) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL bounce_busy e%0d: busy=%b", e, busy);
            end
            checks++;
            if (button_n_db !== ((e >= 10) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL bounce_db e%0d: db=%b", e, button_n_db);
            end
        end
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
        end
`endif
    endtask

    task automatic test_reset_pending();
        button_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (button_n_db !== 1'b1) begin
            errors++;
            $display("FAIL rp_released: db=%b expected 1", button_n_db);
        end
        button_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rp_busy_pre: busy=%b expected 1", busy);
        end
        #0.2 reset = 1'b1;
        #0.1;
        checks++;
        if (button_n_db !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rp_async: db=%b busy=%b expected 1 0", button_n_db, busy);
        end
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (button_n_db !== ((e >= 6) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL rp_db e%0d: db=%b", e, button_n_db);
            end
`ifdef BUTTON_DEBOUNCER_EVENTS_EN
            checks++;
            if (pressed_pulse !== ((e == 6) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL rp_pulse e%0d: pp=%b", e, pressed_pulse);
            end
`endif
        end
    endtask

    task automatic test_single();
        for (int e = 1; e <= 5; e++) begin
            button1_n = 1'b0;
            tick();
            checks++;
            if (button1_n_db !== ((e >= 3) ? 1'b0 : 1'b1) || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL single_press e%0d: db=%b busy=%b", e, button1_n_db, busy1);
            end
        end
        for (int e = 1; e <= 5; e++) begin
            button1_n = 1'b1;
            tick();
            checks++;
            if (button1_n_db !== ((e >= 3) ? 1'b1 : 1'b0) || busy1 !== 1'b0) begin
                errors++;
                $display("FAIL single_release e%0d: db=%b busy=%b", e, button1_n_db, busy1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_reset_pending();
        test_single();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw inverting push-button input before it reaches the falling-edge detector that toggles the LED.
- Synchronises the asynchronous pin to the 50 MHz clock domain with a 2-FF synchroniser.
- Filters contact bounce with a stability counter and a 4-state FSM.
- Outputs a clean, glitch-free inverting level that the edge detector consumes directly in place of the raw button signal.

Parameters:
- STABLE_CYCLES, default 500000: consecutive clock cycles the synchronised input must hold a new level before the output follows (10 ms at 50 MHz). Legal range ≥ 1.
- Counter width: $clog2(STABLE_CYCLES+1).

Ports:
- clock  input  1  50 MHz system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- button_n  input  1  raw inverting button, 0 = pressed. Asynchronous and bouncing.
- button_n_db  output  1  debounced, synchronised inverting level, 0 = pressed. Drives the edge detector's button input.
- busy  output  1  high while a level change is pending (stability window running).

Behaviour:
- Reset (async, immediate on assertion):
  - sync FFs = 1, button_n_db = 1, busy = 0, counter = 0, state = RELEASED.
  - Event pulses = 0 when the optional feature is compiled in.
- Synchroniser: button_n -> ff1 -> ff2. "s" = ff2. The FSM only ever samples s, never button_n.
- FSM states: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
- RELEASED (db=1):
  - s=0 with STABLE_CYCLES=1 -> commit directly to PRESSED.
  - s=0 otherwise -> PRESS_PENDING, counter=1.
  - s=1 -> stay.
- PRESS_PENDING (db=1, busy=1):
  - s=1 -> RELEASED, counter=0 (bounce rejected).
  - s=0 and counter+1 == STABLE_CYCLES -> commit: PRESSED, db<=0, counter=0.
  - otherwise counter++.
- PRESSED and RELEASE_PENDING mirror RELEASED and PRESS_PENDING with the levels inverted. A commit drives db<=1.
- Rule: button_n_db changes on the edge at which s has been sampled at the new level on STABLE_CYCLES consecutive edges.
- Latency: a clean raw level change settled before edge e1 appears on button_n_db at edge e(STABLE_CYCLES+2): 2 synchroniser edges + STABLE_CYCLES.
- Bounce on the would-be commit edge: decided by the s sampled at that edge. If s has reverted, abort to the stable state and leave db unchanged.
- Counter never exceeds STABLE_CYCLES and is cleared on every state exit. There is no wrap-around.
- busy is a registered copy of (state is a *_PENDING state). It is never 1 when STABLE_CYCLES=1.
- Reset mid-pending: everything returns to reset values and the pending count is discarded.
  - Input held low through reset deassertion -> full latency measured from the first edge after deassert.
- All outputs are registered; there is no combinational path from button_n to any output.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_EVENTS_EN.
- Defined: adds outputs pressed_pulse and released_pulse (1 bit each).
  - Each is high for exactly one cycle, registered on the same edge that button_n_db falls (pressed_pulse) or rises (released_pulse).
  - Both reset to 0. Never simultaneously high.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use STABLE_CYCLES=4, 1 ns clock, feature macro defined unless stated.
1. Reset=1, button_n=1, then release reset -> button_n_db=1, busy=0, both pulses 0. Reassert reset asynchronously mid-cycle -> outputs forced to reset values immediately.
2. button_n 1->0 before edge e1, held low:
   - busy=1 after e3 through e5.
   - button_n_db falls at e6.
   - pressed_pulse=1 for exactly the e6 cycle.
3. Bounce: button_n low for 3 edges, high 1 edge, then low steady:
   - busy drops to 0 after the bounce.
   - button_n_db stays 1 until the 6th edge after the final falling transition.
   - Single pressed_pulse.
4. From pressed, button_n 0->1 held -> button_n_db rises at 6th edge, released_pulse one cycle. A 2-cycle release glitch is rejected, with db staying 0.
5. Reset asserted while busy=1 in PRESS_PENDING, button_n held 0 across deassert:
   - db=1 and busy=0 immediately.
   - db falls on the 6th edge after reset deassertion.
6. STABLE_CYCLES=1 with the macro undefined (elaboration without pulse ports OK):
   - button_n 1->0 -> button_n_db falls at e3.
   - busy never asserted.
